imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Fetch sequencer for the 32-bit RISC-V core's instruction memory.
- Owns the program counter and drives the byte address into the combinational, word-indexed instruction memory (word = addr[7:2]).
- Buffers fetched words in a 2-entry FIFO and hands them to decode over a valid/ready handshake.
- Supports stall (backpressure), halt, and branch/jump redirect with flush.

Parameters:
- ADDR_W, 8, byte-address width of instruction memory.
- DATA_W, 32, instruction width.
- RESET_PC, 8'h00, PC value after reset; must be a multiple of 4.
- DEPTH, 2, fetch FIFO entries; fixed power of 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- imem_addr  out  ADDR_W  byte address to instruction memory (= pc)
- imem_instr  in  DATA_W  combinational read data for imem_addr
- halt  in  1  level; stop issuing new fetches
- redirect_valid  in  1  one-cycle pulse; branch/jump taken
- redirect_pc  in  ADDR_W  target byte address
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_instr  out  DATA_W  FIFO head instruction
- out_pc  out  ADDR_W  FIFO head PC
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0
- state  out  2  FSM state (debug)
- fetch_count  out  16  saturating count of pushed instructions

Behaviour:
- Reset (rst_n low at a clk edge):
  - pc=RESET_PC, FIFO empty, out_valid=0, out_instr=0, out_pc=0.
  - misalign_err=0, fetch_count=0, state=BOOT.
- FSM states: BOOT=0, RUN=1, HALTED=2.
  - BOOT -> RUN unconditionally (one idle cycle; no fetch in BOOT).
  - RUN -> HALTED when halt=1.
  - HALTED -> RUN when halt=0.
  - Redirect is legal in any state other than BOOT; it does not change state.
- imem_addr = pc at all times (combinational from the pc register).
- pop = out_valid & out_ready.
- push = (state==RUN) & ~halt & ~redirect_valid & (~full | pop).
  - On push: enqueue {pc, imem_instr}; pc <= pc + 4, wrapping mod 2^ADDR_W (8'hFC -> 8'h00).
- Redirect (redirect_valid=1, state!=BOOT):
  - Flush FIFO: count=0, any same-cycle pop is discarded.
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}. No push that cycle.
  - misalign_err=1 for one cycle if redirect_pc[1:0]!=0.
  - Fetch of the target begins the next cycle if RUN & ~halt.
  - Redirect during HALTED updates pc and flushes, but does not fetch.
- Latency: a word whose pc is presented in cycle N is visible on out_instr/out_pc with out_valid=1 after edge N. Zero bubbles at steady state with out_ready=1.
- Full (2 entries) with pop in the same cycle: push allowed (pass-through).
- Full without pop: pc holds; imem_addr stable.
- Empty with out_ready=1: no pop; out_valid=0; out_instr/out_pc hold their last value.
- Halt: takes effect the same cycle (no push). FIFO continues to drain.
- fetch_count increments on push and saturates at 16'hFFFF. It is not cleared by redirect.
- Simultaneous halt and redirect: both apply (flush, load pc, no fetch, go HALTED).

Decomposition:
- Shared package fetch_pkg:
  - FSM state encodings (ST_BOOT, ST_RUN, ST_HALTED).
  - PC_STEP=4.
  - Instruction/address width constants.
- One sub-module, fetch_fifo: DEPTH-entry synchronous FIFO.
  - Ports: push, pop, flush, din, dout, full, empty.
  - Flush has priority over push and pop.
- The controller holds the pc register, FSM, counter and handshake logic.

Test Plan:
- Reset release, out_ready=1, memory loaded with 0x00007033, 0x00100093, 0x00200113:
  - Cycle 1 = BOOT.
  - Then out_pc 0x00,0x04,0x08 with those instructions on consecutive cycles; fetch_count=3.
- out_ready=0 for 5 cycles after 2 pushes:
  - FIFO holds pc 0x00, 0x04; imem_addr stuck at 0x08.
  - Release -> 0x00,0x04,0x08 delivered in order, nothing lost or duplicated.
- Redirect to 0x48 while FIFO holds 0x10,0x14:
  - Next cycle out_valid=0, misalign_err=0.
  - Following cycle out_pc=0x48, out_instr=memory[18]=0x02b02823.
- Redirect to 0x4B:
  - misalign_err pulses 1 cycle; next delivered out_pc=0x48.
- halt=1 for 4 cycles with out_ready=1:
  - FIFO drains, state=HALTED, pc frozen.
  - Deassert -> resumes from the frozen pc, state=RUN.
- pc=0xFC, then rst_n=0 mid-stream:
  - Without reset: wraps 0xFC->0x00.
  - With rst_n=0 for one edge: out_valid=0, fetch_count=0, state=BOOT, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned IMEM_ADDR_W = 8;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned PC_STEP     = 4;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO; flush beats push and pop. The head output
// keeps its last shown value while the FIFO is empty.
module fetch_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? hold_q : mem_q[rd_ptr_q];

    // Next-state for storage, pointers, occupancy and the held head value.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        hold_d   = dout;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, fetches from combinational instruction
// memory into a small FIFO and hands words to decode via valid/ready.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = IMEM_ADDR_W,
    parameter int unsigned        DATA_W   = INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              misalign_err,
    output logic [1:0]        state,
    output logic [15:0]       fetch_count
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [15:0]        fetch_count_q, fetch_count_d;
    logic               misalign_q, misalign_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               pop;
    logic               push;
    logic               redir;

    assign imem_addr    = pc_q;
    assign out_valid    = ~fifo_empty;
    assign out_pc       = fifo_dout[ENTRY_W-1 -: ADDR_W];
    assign out_instr    = fifo_dout[DATA_W-1:0];
    assign misalign_err = misalign_q;
    assign state        = state_q;
    assign fetch_count  = fetch_count_q;

    assign pop   = out_valid & out_ready;
    assign redir = redirect_valid & (state_q != ST_BOOT);
    assign push  = (state_q == ST_RUN) & ~halt & ~redirect_valid & (~fifo_full | pop);

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   ({pc_q, imem_instr}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next FSM state: one idle BOOT cycle, then follow the halt level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (halt)  state_d = ST_HALTED;
            ST_HALTED: if (!halt) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    // Next PC, misalignment pulse and saturating push counter.
    always_comb begin
        pc_d          = pc_q;
        misalign_d    = 1'b0;
        fetch_count_d = fetch_count_q;
        if (redir) begin
            pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
            misalign_d = |redirect_pc[1:0];
        end else if (push) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
        if (push && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural instruction memory.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        halt;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        misalign_err;
    logic [1:0]  state;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[7:2]];

    imem_fetch_ctrl #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .RESET_PC (8'h00),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err),
        .state          (state),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[0]  = 32'h00007033;
        mem[1]  = 32'h00100093;
        mem[2]  = 32'h00200113;
        mem[18] = 32'h02b02823;

        rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; out_ready = 1'b1;

        // Reset release and streaming start
        do_reset();
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(fetch_count), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'h00);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        check("rst_mis", 32'(misalign_err), 32'd0);
        tick();
        check("boot_run", 32'(state), 32'd1);
        check("boot_novalid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("s1_valid", 32'(out_valid), 32'd1);
            check("s1_pc", 32'(out_pc), 32'(4 * k));
            check("s1_instr", out_instr, mem[k]);
            check("s1_count", 32'(fetch_count), 32'(k + 1));
        end

        // Backpressure: two pushes then stall
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_addr", 32'(imem_addr), 32'h08);
            check("bp_pc", 32'(out_pc), 32'h00);
            check("bp_count", 32'(fetch_count), 32'd2);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp_rel_valid", 32'(out_valid), 32'd1);
            check("bp_rel_pc", 32'(out_pc), 32'(4 * k));
            check("bp_rel_instr", out_instr, mem[k]);
            tick();
        end

        // Redirect while FIFO holds 0x10, 0x14
        do_reset();
        tick();
        for (int k = 0; k < 5; k++) tick();
        check("rd_pre_pc", 32'(out_pc), 32'h10);
        out_ready = 1'b0;
        tick();
        check("rd_full_pc", 32'(out_pc), 32'h10);
        check("rd_full_cnt", 32'(fetch_count), 32'd6);
        check("rd_full_addr", 32'(imem_addr), 32'h18);
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 8'h48;
        tick();
        redirect_valid = 1'b0;
        check("rd_flush_valid", 32'(out_valid), 32'd0);
        check("rd_flush_mis", 32'(misalign_err), 32'd0);
        check("rd_flush_addr", 32'(imem_addr), 32'h48);
        tick();
        check("rd_tgt_valid", 32'(out_valid), 32'd1);
        check("rd_tgt_pc", 32'(out_pc), 32'h48);
        check("rd_tgt_instr", out_instr, 32'h02b02823);
        check("rd_tgt_cnt", 32'(fetch_count), 32'd7);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 8'h4B;
        tick();
        redirect_valid = 1'b0;
        check("mis_pulse", 32'(misalign_err), 32'd1);
        check("mis_valid", 32'(out_valid), 32'd0);
        check("mis_addr", 32'(imem_addr), 32'h48);
        tick();
        check("mis_clear", 32'(misalign_err), 32'd0);
        check("mis_pc", 32'(out_pc), 32'h48);
        check("mis_instr", out_instr, 32'h02b02823);

        // Halt with drain
        halt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("halt_state", 32'(state), 32'd2);
            check("halt_valid", 32'(out_valid), 32'd0);
            check("halt_addr", 32'(imem_addr), 32'h4C);
            check("halt_cnt", 32'(fetch_count), 32'd8);
        end
        halt = 1'b0;
        tick();
        check("resume_state", 32'(state), 32'd1);
        check("resume_novalid", 32'(out_valid), 32'd0);
        tick();
        check("resume_pc", 32'(out_pc), 32'h4C);
        check("resume_instr", out_instr, mem[19]);
        check("resume_cnt", 32'(fetch_count), 32'd9);

        // PC wrap at the top of memory
        redirect_valid = 1'b1; redirect_pc = 8'hF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_f8", 32'(out_pc), 32'hF8);
        tick();
        check("wrap_fc", 32'(out_pc), 32'hFC);
        check("wrap_addr", 32'(imem_addr), 32'h00);
        tick();
        check("wrap_pc0", 32'(out_pc), 32'h00);
        check("wrap_instr0", out_instr, mem[0]);

        // Simultaneous halt and redirect
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h20;
        tick();
        redirect_valid = 1'b0;
        check("hr_state", 32'(state), 32'd2);
        check("hr_addr", 32'(imem_addr), 32'h20);
        check("hr_valid", 32'(out_valid), 32'd0);
        tick();
        check("hr_hold_addr", 32'(imem_addr), 32'h20);

        // Mid-stream reset
        halt = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_count", 32'(fetch_count), 32'd0);
        check("mrst_state", 32'(state), 32'd0);
        check("mrst_addr", 32'(imem_addr), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
